// File: rtl/icache_refill_ctrl.sv
// I-cache refill sequencer: latches a miss, issues one line request, assembles the response
// beats into a full line and writes it to the array in one cycle; flushes drain without a fill.
module icache_refill_ctrl #(
  parameter int unsigned ADDR_LEN = 64,
  parameter int unsigned LINE_LEN = 1024,
  parameter int unsigned BEAT_LEN = 64
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic                miss_i,
  input  logic [ADDR_LEN-1:0] miss_addr_i,
  output logic                busy_o,
  output logic                mem_req_valid_o,
  input  logic                mem_req_ready_i,
  output logic [ADDR_LEN-1:0] mem_req_addr_o,
  input  logic                mem_rsp_valid_i,
  input  logic [BEAT_LEN-1:0] mem_rsp_data_i,
  output logic                mem_rsp_ready_o,
  output logic                fill_valid_o,
  output logic [ADDR_LEN-1:0] fill_addr_o,
  output logic [LINE_LEN-1:0] fill_line_o
);

  localparam int unsigned BEATS    = LINE_LEN / BEAT_LEN;
  localparam int unsigned LINE_OFF = $clog2(LINE_LEN / 8);
  localparam int unsigned CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [2:0] {StIdle, StReq, StRecv, StWrite, StDrain} state_e;

  state_e              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [ADDR_LEN-1:0] r_addr, w_addr_nxt;
  logic                r_abort, w_abort_nxt;
  logic [LINE_LEN-1:0] r_line;
  logic                w_line_we;
  logic                w_last;

  assign w_last         = (r_cnt == CNT_W'(BEATS - 1));
  assign mem_req_addr_o = r_addr;
  assign fill_addr_o    = r_addr;
  assign fill_line_o    = r_line;

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_addr_nxt      = r_addr;
    w_abort_nxt     = r_abort;
    w_line_we       = 1'b0;
    busy_o          = (r_state != StIdle);
    mem_req_valid_o = 1'b0;
    mem_rsp_ready_o = 1'b0;
    fill_valid_o    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (miss_i && !flush_i) begin
          w_addr_nxt  = {miss_addr_i[ADDR_LEN-1:LINE_OFF], {LINE_OFF{1'b0}}};
          w_abort_nxt = 1'b0;
          w_state_nxt = StReq;
        end
      end
      StReq: begin
        // The request stays up even when flushed; the abort is remembered for the drain.
        mem_req_valid_o = 1'b1;
        if (flush_i) w_abort_nxt = 1'b1;
        if (mem_req_ready_i) begin
          w_cnt_nxt   = '0;
          w_state_nxt = (flush_i || r_abort) ? StDrain : StRecv;
        end
      end
      StRecv: begin
        mem_rsp_ready_o = 1'b1;
        if (mem_rsp_valid_i) begin
          w_line_we = 1'b1;
          w_cnt_nxt = r_cnt + 1'b1;
          if (w_last) begin
            w_state_nxt = flush_i ? StIdle : StWrite;
          end else if (flush_i) begin
            w_state_nxt = StDrain;
          end
        end else if (flush_i) begin
          w_state_nxt = StDrain;
        end
      end
      StWrite: begin
        fill_valid_o = 1'b1;
        w_state_nxt  = StIdle;
      end
      StDrain: begin
        mem_rsp_ready_o = 1'b1;
        if (mem_rsp_valid_i) begin
          w_cnt_nxt = r_cnt + 1'b1;
          if (w_last) w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_abort <= 1'b0;
      r_line  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_addr  <= w_addr_nxt;
      r_abort <= w_abort_nxt;
      if (w_line_we) r_line[BEAT_LEN*r_cnt +: BEAT_LEN] <= mem_rsp_data_i;
    end
  end

endmodule

// File: doc/icache_refill_ctrl.md
Name: icache_refill_ctrl

Overview:
Sequences I-cache line refills after a lookup miss. It captures the miss address and issues one line-aligned request to the memory side. It assembles the 64-bit response beats into a full line and delivers it as a single-cycle fill write to the I-cache array. It stalls the frontend through busy_o and handles frontend flushes by draining any in-flight refill without writing it.

Parameters:
ADDR_LEN, 64, address width (XLEN)
LINE_LEN, 1024, I-cache line width in bits (32 instructions x ILEN)
BEAT_LEN, 64, memory response beat width
BEATS (derived, not overridable), LINE_LEN/BEAT_LEN = 16, beats per line
LINE_OFF (derived), $clog2(LINE_LEN/8) = 7, byte-offset bits of a line address

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
flush_i  in  1  frontend flush; abort current refill
miss_i  in  1  I-cache lookup miss, sampled only in IDLE
miss_addr_i  in  ADDR_LEN  PC that missed
busy_o  out  1  refill in progress; frontend must stall
mem_req_valid_o  out  1  line request valid
mem_req_ready_i  in  1  memory accepts request
mem_req_addr_o  out  ADDR_LEN  line-aligned request address
mem_rsp_valid_i  in  1  response beat valid
mem_rsp_data_i  in  BEAT_LEN  response beat data, beat 0 first
mem_rsp_ready_o  out  1  controller accepts beat
fill_valid_o  out  1  single-cycle write strobe to cache array
fill_addr_o  out  ADDR_LEN  line-aligned fill address
fill_line_o  out  LINE_LEN  assembled line

Behaviour:
- Reset (rst_i at posedge): state=IDLE, beat counter=0, address and line registers=0, all outputs 0. Reset overrides everything, including mid-refill. Any pending memory transaction is the memory side's responsibility (it is reset together with this block).
- States: IDLE, REQ, RECV, WRITE, DRAIN. busy_o=1 in every state except IDLE.
- IDLE:
  - If miss_i=1 and flush_i=0: latch addr = {miss_addr_i[ADDR_LEN-1:LINE_OFF], LINE_OFF'b0}, go to REQ.
  - flush_i=1 in the same cycle as miss_i: the miss is ignored and the state stays IDLE.
- REQ:
  - mem_req_valid_o=1 and mem_req_addr_o=latched addr. Both are held stable until mem_req_ready_i=1; a flush never withdraws a presented request.
  - On handshake: counter=0; go to RECV, or to DRAIN if a flush was seen (flush_i now or an abort flag set earlier in REQ).
  - flush_i while in REQ sets the abort flag.
- RECV:
  - mem_rsp_ready_o=1. On each beat handshake, store data into line bits [BEAT_LEN*k +: BEAT_LEN], k = counter, then increment counter.
  - On the handshake with counter=BEATS-1: go to WRITE. Counter wraps to 0.
  - flush_i=1 in RECV: go to DRAIN, keeping the counter. A beat accepted in that same cycle is counted. If that beat is the last one, go to IDLE instead.
- WRITE:
  - fill_valid_o=1 for exactly one cycle, with fill_addr_o=latched addr and fill_line_o=assembled line. Then go to IDLE.
  - A flush in WRITE does not suppress the fill, because the line data is valid.
- DRAIN: mem_rsp_ready_o=1. Beats are counted but discarded. After the last beat handshake (counter=BEATS-1), go to IDLE without a fill.
- mem_rsp_ready_o=0 in IDLE, REQ and WRITE. Beats arriving in those states are protocol errors and are not consumed.
- miss_i is ignored outside IDLE; the frontend re-presents the miss after busy_o falls.
- Latency with zero-wait memory:
  - miss at cycle 0, request at cycle 1 (handshake at cycle 1).
  - beats at cycles 2..17, fill_valid_o at cycle 18, busy_o low at cycle 19.
  - A new miss can be accepted at cycle 19.
- fill_valid_o must never be asserted for a refill during which flush_i was seen before the last beat.

Test Plan:
- miss_i with miss_addr_i=0x1234_5678; ready always high; beats data=k -> req addr 0x1234_5600 at cycle 1; fill at cycle 18 with addr 0x1234_5600 and line[64k+:64]=k for k=0..15; busy_o low at cycle 19.
- mem_req_ready_i low for 5 cycles -> valid and addr held stable for 6 cycles; handshake once; then a normal fill.
- flush_i in RECV after 6 beats -> 10 more beats accepted with mem_rsp_ready_o=1; no fill_valid_o; IDLE afterwards; the next miss is serviced normally.
- flush_i in REQ while ready=0 -> request stays valid until accepted; all 16 beats drained; no fill.
- flush_i and miss_i in the same IDLE cycle -> no request issued; busy_o stays 0.
- rst_i asserted during RECV at beat 9 -> next cycle all outputs 0 and state IDLE; a fresh miss then yields a correct fill with no stale beats.
